cache_mem_arbiter: RTL and testbench

//  Two-master to one-slave arbiter for the SRAM-like bus. Sits directly downstream of the instruction

---
 rtl/cache_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Two-master (icache / dcache) to one-slave SRAM-like bus arbiter, one transaction outstanding.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data priority with anti-starvation.
module cache_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t state, state_next;
    logic   owner, owner_next;
    logic   any_req;
    logic   sel;
    logic   cur_owner;
    logic   cur_req;
    logic   resp;

`ifdef ARB_ROUND_ROBIN_EN
    logic   last_owner;
`else
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
    logic [2:0] starve_cnt;
`endif

    // Owner selection while IDLE; owner encoding is 0=inst, 1=data.
    always_comb begin
        any_req = inst_req | data_req;
        sel     = data_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_req && data_req)
            sel = ~last_owner;
`else
        if (inst_req && data_req && (starve_cnt == STARVE_MAX))
            sel = 1'b0;
`endif
    end

    assign cur_owner = (state == IDLE) ? sel : owner;
    assign cur_req   = cur_owner ? data_req : inst_req;

    // Bus forwarding: request only outside DATA, and never while reset is held.
    always_comb begin
        mem_req   = ~rst & (state != DATA) & cur_req;
        mem_wr    = mem_req & (cur_owner ? data_wr : inst_wr);
        mem_size  = cur_owner ? data_size  : inst_size;
        mem_addr  = cur_owner ? data_addr  : inst_addr;
        mem_wdata = cur_owner ? data_wdata : inst_wdata;
    end

    assign inst_addr_ok = mem_addr_ok & mem_req & ~cur_owner;
    assign data_addr_ok = mem_addr_ok & mem_req &  cur_owner;

    assign resp         = ~rst & (state == DATA) & mem_data_ok;
    assign inst_data_ok = resp & ~owner;
    assign data_data_ok = resp &  owner;

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_next = sel;
                    state_next = mem_addr_ok ? DATA : ADDR;
                end
            end
            ADDR: begin
                if (mem_req && mem_addr_ok)
                    state_next = DATA;
            end
            DATA: begin
                if (mem_data_ok)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember who finished last so a tie goes to the other master.
    always_ff @(posedge clk) begin
        if (rst)
            last_owner <= 1'b0;
        else if (resp)
            last_owner <= owner;
    end
`else
    // Counts data grants taken while inst waits; saturates so the tie flips to inst.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (state == IDLE) begin
            if (!inst_req || (any_req && !sel))
                starve_cnt <= 3'd0;
            else if (sel && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter; the bench acts as both caches and the bridge.
module tb_cache_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;

    int total;
    int bad;
    logic [5:0] exp_grant;

    cache_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of cache and bridge inputs at the falling edge, then settle.
    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwr, input logic [31:0] daddr,
                                 input logic [31:0] dwdata, input logic aok, input logic dok,
                                 input logic [31:0] rdata);
        @(negedge clk);
        inst_req    = ireq;
        inst_addr   = iaddr;
        data_req    = dreq;
        data_wr     = dwr;
        data_addr   = daddr;
        data_wdata  = dwdata;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rdata;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'b10; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'b10; data_addr = 0; data_wdata = 0;
        mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_mem_req", 32'(mem_req), 0);
        checkOutput("rst_mem_wr", 32'(mem_wr), 0);
        checkOutput("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);

        // 1: single icache read, bridge accepts immediately, responds 3 cycles later
        applyStimulus(1, 32'h1FC00000, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("t1_mem_req", 32'(mem_req), 1);
        checkOutput("t1_mem_addr", mem_addr, 32'h1FC00000);
        checkOutput("t1_inst_aok", 32'(inst_addr_ok), 1);
        checkOutput("t1_data_aok", 32'(data_addr_ok), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_aok_once", 32'(inst_addr_ok), 0);
        checkOutput("t1_data_req_low", 32'(mem_req), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_no_early_dok", 32'(inst_data_ok), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        checkOutput("t1_inst_dok", 32'(inst_data_ok), 1);
        checkOutput("t1_inst_rdata", inst_rdata, 32'hDEADBEEF);
        checkOutput("t1_data_dok", 32'(data_data_ok), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_dok_once", 32'(inst_data_ok), 0);

        // 2: simultaneous requests, bridge accepts after 2 cycles; data wins
        applyStimulus(1, 32'h100, 1, 0, 32'h200, 0, 0, 0, 0);
        checkOutput("t2_addr_c0", mem_addr, 32'h200);
        checkOutput("t2_no_aok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
        applyStimulus(1, 32'h100, 1, 0, 32'h200, 0, 0, 0, 0);
        checkOutput("t2_addr_c1", mem_addr, 32'h200);
        checkOutput("t2_req_c1", 32'(mem_req), 1);
        applyStimulus(1, 32'h100, 1, 0, 32'h200, 0, 1, 0, 0);
        checkOutput("t2_data_aok", 32'(data_addr_ok), 1);
        checkOutput("t2_inst_aok", 32'(inst_addr_ok), 0);
        applyStimulus(1, 32'h100, 0, 0, 32'h200, 0, 0, 1, 32'h0000AAAA);
        checkOutput("t2_data_dok", 32'(data_data_ok), 1);
        checkOutput("t2_inst_dok", 32'(inst_data_ok), 0);
        checkOutput("t2_req_in_data", 32'(mem_req), 0);
        applyStimulus(1, 32'h100, 0, 0, 32'h200, 0, 1, 0, 0);
        checkOutput("t2_inst_addr", mem_addr, 32'h100);
        checkOutput("t2_inst_aok_late", 32'(inst_addr_ok), 1);
        applyStimulus(0, 32'h100, 0, 0, 32'h200, 0, 0, 1, 32'h0000BBBB);
        checkOutput("t2_inst_dok_late", 32'(inst_data_ok), 1);

        // 3: both held continuously; grant order per arbitration mode (bit g = data won grant g)
`ifdef ARB_ROUND_ROBIN_EN
        exp_grant = 6'b010101;
`else
        exp_grant = 6'b101111;
`endif
        for (int g = 0; g < 6; g++) begin
            applyStimulus(1, 32'h300, 1, 0, 32'h400, 0, 1, 0, 0);
            checkOutput($sformatf("t3_g%0d_data_aok", g), 32'(data_addr_ok), 32'(exp_grant[g]));
            checkOutput($sformatf("t3_g%0d_inst_aok", g), 32'(inst_addr_ok), 32'(!exp_grant[g]));
            applyStimulus(1, 32'h300, 1, 0, 32'h400, 0, 0, 1, 32'h5A5A0000 + 32'(g));
            checkOutput($sformatf("t3_g%0d_data_dok", g), 32'(data_data_ok), 32'(exp_grant[g]));
            checkOutput($sformatf("t3_g%0d_inst_dok", g), 32'(inst_data_ok), 32'(!exp_grant[g]));
        end

        // 4: dcache write-back
        applyStimulus(0, 0, 1, 1, 32'h80000040, 32'h12345678, 1, 0, 0);
        checkOutput("t4_mem_wr", 32'(mem_wr), 1);
        checkOutput("t4_mem_wdata", mem_wdata, 32'h12345678);
        checkOutput("t4_mem_size", 32'(mem_size), 32'h2);
        checkOutput("t4_mem_addr", mem_addr, 32'h80000040);
        checkOutput("t4_data_aok", 32'(data_addr_ok), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("t4_data_dok", 32'(data_data_ok), 1);

        // 5: reset while in DATA, then a stale response from the bridge
        applyStimulus(0, 0, 1, 0, 32'h500, 0, 1, 0, 0);
        checkOutput("t5_data_aok", 32'(data_addr_ok), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        checkOutput("t5_req_after_rst", 32'(mem_req), 0);
        mem_data_ok = 1'b1;
        #1;
        checkOutput("t5_stale_dok", {30'd0, inst_data_ok, data_data_ok}, 0);

        // 6: back-to-back data reads, one outstanding at a time
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 0, 32'h600 + 32'(k * 4), 0, 1, 0, 0);
            checkOutput($sformatf("t6_%0d_addr", k), mem_addr, 32'h600 + 32'(k * 4));
            checkOutput($sformatf("t6_%0d_aok", k), {30'd0, inst_addr_ok, data_addr_ok}, 32'h1);
            checkOutput($sformatf("t6_%0d_no_dok", k), 32'(data_data_ok), 0);
            applyStimulus(0, 0, 1, 0, 32'h700, 0, 1, 1, 32'hC0DE0000 + 32'(k));
            checkOutput($sformatf("t6_%0d_req_low", k), 32'(mem_req), 0);
            checkOutput($sformatf("t6_%0d_oks", k), {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'h1);
            checkOutput($sformatf("t6_%0d_rdata", k), data_rdata, 32'hC0DE0000 + 32'(k));
        end

        // 7: owner drops req in ADDR; the other master must stay ignored
        applyStimulus(0, 32'h900, 1, 0, 32'hA00, 0, 0, 0, 0);
        checkOutput("t7_req_addr", 32'(mem_req), 1);
        applyStimulus(1, 32'h900, 0, 0, 32'hA00, 0, 1, 0, 0);
        checkOutput("t7_req_dropped", 32'(mem_req), 0);
        checkOutput("t7_no_aok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
        applyStimulus(1, 32'h900, 1, 0, 32'hA00, 0, 1, 0, 0);
        checkOutput("t7_addr_owner", mem_addr, 32'hA00);
        checkOutput("t7_aok_owner", {30'd0, inst_addr_ok, data_addr_ok}, 32'h1);
        applyStimulus(1, 32'h900, 0, 0, 32'hA00, 0, 0, 1, 0);
        checkOutput("t7_dok_owner", {30'd0, inst_data_ok, data_data_ok}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
